jk_pattern_driver: RTL

Drives an external JK flip-flop (the team's `JK_FF`) through a requested sequence of Q values. It applies the JK excitation table: given the current state and a target next state, it produces J/K. Each target bit is then checked against the flip-flop's observed Q, and mismatches are reported. It is the inverse of the flip-flop's characteristic equation and serves as the lab's self-checking stimulus engine for flip-flop bring-up.

---
 rtl/jk_pkg.sv | 21 ++
 rtl/JK_FF.sv | 24 ++
 rtl/jk_pattern_driver.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// Shared definitions for the JK flip-flop pattern driver: state encoding and
// the JK excitation table (inverse of the flip-flop characteristic equation).
package jk_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_VERIFY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Returns {J,K}. xfill picks how the don't-care half of each row is filled:
    // 0 keeps the unused input low, 1 drives it high (toggle-style).
    function automatic logic [1:0] jk_excite(input logic cur, input logic nxt, input logic xfill);
        if (xfill) begin
            return {cur | nxt, ~(cur & nxt)};
        end
        return {~cur & nxt, cur & ~nxt};
    endfunction

endpackage

// File: rtl/JK_FF.sv
// Lab JK flip-flop: samples J/K on the falling clock edge when ce is high.
module JK_FF (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (ce) begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_pattern_driver.sv
// Drives an external JK flip-flop through a target Q sequence and checks each
// applied bit against the observed Q.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// S_IDLE   | waiting for start; J/K parked at 0/0
// S_DRIVE  | J/K for pattern[idx] presented; flip-flop samples on falling edge
// S_VERIFY | J/K held; observed Q compared with pattern[idx] at cycle end
// S_DONE   | one-cycle done pulse; J/K back to 0/0
module jk_pattern_driver
    import jk_pkg::*;
#(
    parameter int   WIDTH = 8,
    parameter bit   XFILL = 1'b0,
    localparam int  LW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LW-1:0]    len,
    input  logic             q_in,
    output logic             j_out,
    output logic             k_out,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [LW-1:0]    err_count,
    output logic [LW-1:0]    err_idx
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [LW-1:0] LEN_MAX = LW'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LW-1:0]    len_q, len_d;
    logic [LW-1:0]    idx_q, idx_d;
    logic             cur_q, cur_d;
    logic             j_q, j_d;
    logic             k_q, k_d;
    logic             mismatch_q, mismatch_d;
    logic [LW-1:0]    err_count_q, err_count_d;
    logic [LW-1:0]    err_idx_q, err_idx_d;
    logic [LW-1:0]    len_clamped;

    assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            cur_q       <= 1'b0;
            j_q         <= 1'b0;
            k_q         <= 1'b0;
            mismatch_q  <= 1'b0;
            err_count_q <= '0;
            err_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            cur_q       <= cur_d;
            j_q         <= j_d;
            k_q         <= k_d;
            mismatch_q  <= mismatch_d;
            err_count_q <= err_count_d;
            err_idx_q   <= err_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        len_d       = len_q;
        idx_d       = idx_q;
        cur_d       = cur_q;
        j_d         = j_q;
        k_d         = k_q;
        mismatch_d  = mismatch_q;
        err_count_d = err_count_q;
        err_idx_d   = err_idx_q;

        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    pat_d       = pattern;
                    len_d       = len_clamped;
                    cur_d       = q_in;
                    idx_d       = '0;
                    mismatch_d  = 1'b0;
                    err_count_d = '0;
                    err_idx_d   = '0;
                    state_d     = (len_clamped == '0) ? S_DONE : S_DRIVE;
                end
            end
            S_DRIVE: begin
                state_d = S_VERIFY;
            end
            S_VERIFY: begin
                if (q_in != pat_q[idx_q[IW-1:0]]) begin
                    err_count_d = err_count_q + LW'(1);
                    mismatch_d  = 1'b1;
                    if (!mismatch_q) begin
                        err_idx_d = idx_q;
                    end
                end
                // Resync to what the flip-flop actually holds, not what was asked for.
                cur_d = q_in;
                if (idx_q == len_q - LW'(1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + LW'(1);
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // J/K are registered, so they are loaded on the edge that enters DRIVE.
        case (state_d)
            S_DRIVE: begin
                {j_d, k_d} = jk_excite(cur_d, pat_d[idx_d[IW-1:0]], XFILL);
            end
            S_VERIFY: begin
                j_d = j_q;
                k_d = k_q;
            end
            default: begin
                j_d = 1'b0;
                k_d = 1'b0;
            end
        endcase
    end

    assign start_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign j_out       = j_q;
    assign k_out       = k_q;
    assign mismatch    = mismatch_q;
    assign err_count   = err_count_q;
    assign err_idx     = err_idx_q;

endmodule
